// File: rtl/ttt_button_conditioner.sv
// Tic-tac-toe input front-end: synchronises and debounces the square and start
// buttons, then arbitrates clean presses into single-cycle move events.
module ttt_button_conditioner #(
    parameter int unsigned NUM_BTN         = 9,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               start_raw,
    output logic [NUM_BTN-1:0] btn_held,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [3:0]         btn_idx,
    output logic               btn_valid,
    output logic               conflict,
    output logic               start_pulse
);
    localparam int unsigned NUM_CH = NUM_BTN + 1;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned IDX_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Channel NUM_BTN is the start button; channels below it are the squares.
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]                  deb_q, deb_d;
    logic [NUM_CH-1:0]                  deb_prev_q, deb_prev_d;
    logic [NUM_CH-1:0]                  sync_out;

    state_e             state_q, state_d;
    logic [NUM_BTN-1:0] btn_pulse_q, btn_pulse_d;
    logic [IDX_W-1:0]   btn_idx_q, btn_idx_d;
    logic               btn_valid_q, btn_valid_d;
    logic               conflict_q, conflict_d;
    logic               start_pulse_q, start_pulse_d;

    logic [NUM_BTN-1:0] deb_btn;
    logic [NUM_BTN-1:0] rise;
    logic [IDX_W-1:0]   rise_idx;
    logic               multi_held;
    logic               start_rise;

    // Synchroniser chains and per-channel debounce counters.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], {start_raw, btn_raw}};
        sync_out   = sync_q[SYNC_STAGES-1];
        cnt_d      = '0;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (sync_out[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge detection and move arbitration.
    always_comb begin
        deb_btn       = deb_q[NUM_BTN-1:0];
        rise          = deb_btn & ~deb_prev_q[NUM_BTN-1:0];
        start_rise    = deb_q[NUM_BTN] & ~deb_prev_q[NUM_BTN];
        // More than one square held: clearing the lowest set bit leaves something.
        multi_held    = |(deb_btn & (deb_btn - NUM_BTN'(1)));
        rise_idx      = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            if (rise[i]) begin
                rise_idx = IDX_W'(i);
            end
        end

        state_d       = state_q;
        btn_pulse_d   = '0;
        btn_idx_d     = '0;
        btn_valid_d   = 1'b0;
        conflict_d    = 1'b0;
        start_pulse_d = start_rise;

        case (state_q)
            IDLE: begin
                if (|rise) begin
                    state_d = LOCKED;
                    if (multi_held) begin
                        conflict_d = 1'b1;
                    end else begin
                        btn_valid_d = 1'b1;
                        btn_pulse_d = rise;
                        btn_idx_d   = rise_idx;
                    end
                end
            end
            LOCKED: begin
                if (|rise) begin
                    conflict_d = 1'b1;
                end else if (deb_btn == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q        <= '0;
            cnt_q         <= '0;
            deb_q         <= '0;
            deb_prev_q    <= '0;
            state_q       <= IDLE;
            btn_pulse_q   <= '0;
            btn_idx_q     <= '0;
            btn_valid_q   <= 1'b0;
            conflict_q    <= 1'b0;
            start_pulse_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            deb_q         <= deb_d;
            deb_prev_q    <= deb_prev_d;
            state_q       <= state_d;
            btn_pulse_q   <= btn_pulse_d;
            btn_idx_q     <= btn_idx_d;
            btn_valid_q   <= btn_valid_d;
            conflict_q    <= conflict_d;
            start_pulse_q <= start_pulse_d;
        end
    end

    assign btn_held    = deb_q[NUM_BTN-1:0];
    assign btn_pulse   = btn_pulse_q;
    assign btn_idx     = btn_idx_q;
    assign btn_valid   = btn_valid_q;
    assign conflict    = conflict_q;
    assign start_pulse = start_pulse_q;

endmodule

// File: tb/tb_ttt_button_conditioner.sv
// Bench for ttt_button_conditioner: phase table, exact-latency and reset sequences,
// and random press patterns compared every cycle against a sample-window model.
module tb_ttt_button_conditioner;
    localparam int NB = 9;
    localparam int SS = 2;
    localparam int DC = 4;

    logic          clk, reset, start_raw;
    logic [NB-1:0] btn_raw, btn_held, btn_pulse;
    logic [3:0]    btn_idx;
    logic          btn_valid, conflict, start_pulse;

    int checks   = 0;
    int failures = 0;
    int n_valid, n_conf, n_start, last_idx;

    // Reference model: raw sample history, debounced levels, lock flag, expected strobes.
    logic [NB:0]   rhist[$];
    int            m_edge;
    logic [NB:0]   m_deb, m_prev;
    bit            m_locked;
    int            m_last_flip[NB+1];
    logic [NB-1:0] e_pulse;
    logic [3:0]    e_idx;
    logic          e_valid, e_conf, e_start;

    typedef struct {
        logic [NB-1:0] btn;
        logic          start;
        int            cycles;
        int            exp_valid;
        int            exp_conf;
        int            exp_start;
        int            exp_idx;
        logic [NB-1:0] exp_held;
    } vec_t;
    vec_t tbl[$];

    ttt_button_conditioner #(
        .NUM_BTN        (NB),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .start_raw  (start_raw),
        .btn_held   (btn_held),
        .btn_pulse  (btn_pulse),
        .btn_idx    (btn_idx),
        .btn_valid  (btn_valid),
        .conflict   (conflict),
        .start_pulse(start_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({btn_held, btn_pulse, btn_idx, btn_valid, conflict, start_pulse});
    endfunction

    task automatic model_reset();
        rhist.delete();
        m_edge   = 0;
        m_deb    = '0;
        m_prev   = '0;
        m_locked = 1'b0;
        for (int c = 0; c <= NB; c++) m_last_flip[c] = -1000;
        e_pulse = '0; e_idx = '0; e_valid = 1'b0; e_conf = 1'b0; e_start = 1'b0;
    endtask

    // Raw level present just before edge e; everything before reset release reads 0.
    function automatic logic samp(input int ch, input int e);
        if (e < 1) return 1'b0;
        return rhist[e-1][ch];
    endfunction

    task automatic model_step(input logic [NB:0] r);
        logic [NB-1:0] rise;
        bit            all_diff;
        rhist.push_back(r);
        m_edge++;
        rise    = m_deb[NB-1:0] & ~m_prev[NB-1:0];
        e_pulse = '0; e_idx = '0; e_valid = 1'b0; e_conf = 1'b0;
        if (rise != '0) begin
            if (!m_locked && $countones(m_deb[NB-1:0]) == 1) begin
                e_valid = 1'b1;
                e_pulse = rise;
                e_idx   = 4'($clog2(rise));
            end else begin
                e_conf = 1'b1;
            end
            m_locked = 1'b1;
        end else if (m_deb[NB-1:0] == '0) begin
            m_locked = 1'b0;
        end
        e_start = m_deb[NB] & ~m_prev[NB];
        m_prev  = m_deb;
        // A level flips once DC consecutive synchronised samples disagree with it,
        // counting only samples taken after its previous flip.
        for (int c = 0; c <= NB; c++) begin
            if (m_edge - m_last_flip[c] >= DC) begin
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (samp(c, m_edge - SS - k) == m_deb[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_deb[c]       = ~m_deb[c];
                    m_last_flip[c] = m_edge;
                end
            end
        end
    endtask

    task automatic clear_counts();
        n_valid = 0; n_conf = 0; n_start = 0; last_idx = -1;
    endtask

    task automatic step(input logic [NB-1:0] b, input logic s);
        btn_raw   = b;
        start_raw = s;
        @(posedge clk);
        model_step({s, b});
        #1;
        check("model", outs(), 32'({m_deb[NB-1:0], e_pulse, e_idx, e_valid, e_conf, e_start}));
        if (btn_valid) begin n_valid++; last_idx = int'(btn_idx); end
        if (conflict) n_conf++;
        if (start_pulse) n_start++;
    endtask

    initial begin
        logic [NB-1:0] b;
        logic          s;
        int            dur;

        reset = 1'b0; btn_raw = '0; start_raw = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 32'(0));
        reset = 1'b1;

        // Exact press latency for square 4.
        clear_counts();
        for (int e = 1; e <= 9; e++) begin
            step(9'h010, 1'b0);
            check("lat_held4", 32'(btn_held[4]), 32'(e >= 6));
            check("lat_valid", 32'(btn_valid), 32'(e == 7));
            if (e == 7) begin
                check("lat_pulse", 32'(btn_pulse), 32'(9'h010));
                check("lat_idx", 32'(btn_idx), 32'(4));
            end
        end
        repeat (12) step('0, 1'b0);

        tbl.push_back('{9'h000, 1'b0, 20, 0, 0, 0, -1, 9'h000});
        tbl.push_back('{9'h010, 1'b0, 30, 1, 0, 0,  4, 9'h010});
        tbl.push_back('{9'h000, 1'b0, 12, 0, 0, 0, -1, 9'h000});
        tbl.push_back('{9'h004, 1'b0,  3, 0, 0, 0, -1, 9'h000});
        tbl.push_back('{9'h000, 1'b0, 10, 0, 0, 0, -1, 9'h000});
        tbl.push_back('{9'h001, 1'b0, 10, 1, 0, 0,  0, 9'h001});
        tbl.push_back('{9'h101, 1'b0, 20, 0, 1, 0, -1, 9'h101});
        tbl.push_back('{9'h000, 1'b0, 12, 0, 0, 0, -1, 9'h000});
        tbl.push_back('{9'h100, 1'b0, 12, 1, 0, 0,  8, 9'h100});
        tbl.push_back('{9'h000, 1'b0, 12, 0, 0, 0, -1, 9'h000});
        tbl.push_back('{9'h082, 1'b0, 12, 0, 1, 0, -1, 9'h082});
        tbl.push_back('{9'h000, 1'b0, 12, 0, 0, 0, -1, 9'h000});
        tbl.push_back('{9'h000, 1'b1,  6, 0, 0, 0, -1, 9'h000});
        tbl.push_back('{9'h000, 1'b0, 12, 0, 0, 1, -1, 9'h000});

        foreach (tbl[i]) begin
            clear_counts();
            repeat (tbl[i].cycles) step(tbl[i].btn, tbl[i].start);
            check($sformatf("vec%0d_valid", i), 32'(n_valid), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d_conflict", i), 32'(n_conf), 32'(tbl[i].exp_conf));
            check($sformatf("vec%0d_start", i), 32'(n_start), 32'(tbl[i].exp_start));
            check($sformatf("vec%0d_held", i), 32'(btn_held), 32'(tbl[i].exp_held));
            if (tbl[i].exp_valid > 0)
                check($sformatf("vec%0d_idx", i), 32'(last_idx), 32'(tbl[i].exp_idx));
        end

        // Random press patterns, including short glitches and overlapping presses.
        b = '0;
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = '0;
                4, 5, 6, 7: b = 9'h001 << $urandom_range(0, 8);
                8:          b = (9'h001 << $urandom_range(0, 8)) | (9'h001 << $urandom_range(0, 8));
                default:    b = b ^ (9'h001 << $urandom_range(0, 8));
            endcase
            s   = ($urandom_range(0, 3) == 0);
            dur = $urandom_range(1, 14);
            repeat (dur) step(b, s);
        end

        // Reset asserted while square 5 is held.
        repeat (20) step('0, 1'b0);
        clear_counts();
        repeat (15) step(9'h020, 1'b0);
        check("pre_reset_valid", 32'(n_valid), 32'(1));
        check("pre_reset_idx", 32'(last_idx), 32'(5));
        check("pre_reset_held", 32'(btn_held), 32'(9'h020));
        reset = 1'b0;
        #1;
        check("reset_async", outs(), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", outs(), 32'(0));
        reset = 1'b1;
        model_reset();
        for (int e = 1; e <= 9; e++) begin
            step(9'h020, 1'b0);
            check("rst_valid_edge", 32'(btn_valid), 32'(e == 7));
            if (e == 7) check("rst_idx", 32'(btn_idx), 32'(5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
